// File: rtl/dma_if_64to32_pkg.sv
// Shared definitions for the 64-to-32 tohost DMA width converter:
// FSM state encoding and the legal tkeep patterns for a 64-bit beat.
package dma_if_64to32_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HI    = 2'd1,
    S_LAST  = 2'd2
  } state_e;

  localparam logic [7:0] KEEP_FULL = 8'hff;
  localparam logic [7:0] KEEP_HALF = 8'h0f;

endpackage

// File: rtl/dma_if_64to32.sv
// Splits 64-bit tohost DMA beats into 32-bit host FIFO words, upper word first,
// sustaining one output word per cycle with registered outputs.
module dma_if_64to32
  import dma_if_64to32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] s1_axis_tohost_tdata,
  input  logic        s1_axis_tohost_tvalid,
  input  logic [7:0]  s1_axis_tohost_tkeep,
  input  logic        s1_axis_tohost_tlast,
  output logic        s1_axis_tohost_tready,
  output logic [31:0] m1_axis_tohost_tdata,
  output logic        m1_axis_tohost_tvalid,
  output logic [3:0]  m1_axis_tohost_tkeep,
  output logic        m1_axis_tohost_tlast,
  input  logic        m1_axis_tohost_tready,
  output logic        keep_err
);

  state_e      state_q, state_d;
  logic [31:0] m_tdata_q, m_tdata_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tlast_q, m_tlast_d;
  logic [31:0] lo_reg_q, lo_reg_d;
  logic        lo_last_q, lo_last_d;
  logic        keep_err_q, keep_err_d;
  logic        s_accept;
  logic        half_beat;

  // A new beat can only be taken when the output register is free this cycle.
  assign s1_axis_tohost_tready = (state_q == S_EMPTY) ||
                                 ((state_q == S_LAST) && m1_axis_tohost_tready);
  assign s_accept  = s1_axis_tohost_tvalid && s1_axis_tohost_tready;
  assign half_beat = (s1_axis_tohost_tkeep == KEEP_HALF) && s1_axis_tohost_tlast;

  always_comb begin
    state_d    = state_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    lo_reg_d   = lo_reg_q;
    lo_last_d  = lo_last_q;
    keep_err_d = 1'b0;

    unique case (state_q)
      S_HI: begin
        if (m1_axis_tohost_tready) begin
          m_tdata_d = lo_reg_q;
          m_tlast_d = lo_last_q;
          state_d   = S_LAST;
        end
      end
      S_LAST: begin
        if (m1_axis_tohost_tready && !s_accept) begin
          m_tvalid_d = 1'b0;
          m_tlast_d  = 1'b0;
          state_d    = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Illegal keep patterns fall back to full-beat handling and are flagged.
    if (s_accept) begin
      m_tvalid_d = 1'b1;
      if (half_beat) begin
        m_tdata_d = s1_axis_tohost_tdata[31:0];
        m_tlast_d = 1'b1;
        state_d   = S_LAST;
      end else begin
        m_tdata_d  = s1_axis_tohost_tdata[63:32];
        m_tlast_d  = 1'b0;
        lo_reg_d   = s1_axis_tohost_tdata[31:0];
        lo_last_d  = s1_axis_tohost_tlast;
        keep_err_d = (s1_axis_tohost_tkeep != KEEP_FULL);
        state_d    = S_HI;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      lo_reg_q   <= '0;
      lo_last_q  <= 1'b0;
      keep_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      lo_reg_q   <= lo_reg_d;
      lo_last_q  <= lo_last_d;
      keep_err_q <= keep_err_d;
    end
  end

  assign m1_axis_tohost_tdata  = m_tdata_q;
  assign m1_axis_tohost_tvalid = m_tvalid_q;
  assign m1_axis_tohost_tlast  = m_tlast_q;
  assign m1_axis_tohost_tkeep  = m_tvalid_q ? 4'hf : 4'h0;
  assign keep_err              = keep_err_q;

endmodule
